// File: rtl/key_debounce_array_if.sv
// Key-array bus: sample strobe and raw pins in,
// debounced levels and per-key event pulses out.
interface key_debounce_array_if #(
  parameter int N_KEYS = 4
);
  logic              sample_tick;
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] long_pulse;
  logic [N_KEYS-1:0] repeat_pulse;
  logic              key_any;

  modport master (
    output sample_tick,
    output key_raw,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  key_any
  );

  modport slave (
    input  sample_tick,
    input  key_raw,
    output key_level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output repeat_pulse,
    output key_any
  );
endinterface

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop sync, debounce counter,
// IDLE/PRESSED/LONG hold FSM and registered pulses.
module key_debounce_chan #(
  parameter int ACTIVE_LOW = 1,
  parameter int STABLE_CNT = 3,
  parameter int LONG_CNT   = 100,
  parameter int REPEAT_CNT = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_tick,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);
  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam int HW = $clog2(LONG_CNT + 1);
  localparam int RW =
    (REPEAT_CNT > 0) ? $clog2(REPEAT_CNT + 1) : 1;
  localparam logic [SW-1:0] STAB_TGT = SW'(STABLE_CNT);
  localparam logic [HW-1:0] HOLD_TGT = HW'(LONG_CNT);
  localparam logic [RW-1:0] REP_TGT  = RW'(REPEAT_CNT);
  localparam logic INACTIVE = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic          rpt_q, rpt_d;

  logic          s;
  logic          rise;
  logic          fall;
  logic [SW-1:0] stab_inc;
  logic [HW-1:0] hold_inc;
  logic [RW-1:0] rep_inc;

  always_comb begin
    sync1_d  = key_raw;
    sync2_d  = sync1_q;
    state_d  = state_q;
    level_d  = level_q;
    stab_d   = stab_q;
    hold_d   = hold_q;
    rep_d    = rep_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    long_d   = 1'b0;
    rpt_d    = 1'b0;
    s        = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    stab_inc = stab_q + SW'(1);
    hold_inc = (hold_q == HOLD_TGT) ? hold_q
                                    : hold_q + HW'(1);
    rep_inc  = rep_q + RW'(1);
    rise     = 1'b0;
    fall     = 1'b0;
    if (sample_tick) begin
      // one agreeing sample restarts the count
      if (s == level_q) begin
        stab_d = '0;
      end else if (stab_inc == STAB_TGT) begin
        level_d = s;
        stab_d  = '0;
        rise    = s;
        fall    = ~s;
      end else begin
        stab_d = stab_inc;
      end
      unique case (1'b1)
        rise: begin
          state_d = PRESSED;
          press_d = 1'b1;
          hold_d  = '0;
          rep_d   = '0;
        end
        fall: begin
          state_d = IDLE;
          rel_d   = 1'b1;
          hold_d  = '0;
          rep_d   = '0;
        end
        default: begin
          unique case (state_q)
            PRESSED: begin
              hold_d = hold_inc;
              if (hold_inc == HOLD_TGT) begin
                state_d = LONG;
                long_d  = 1'b1;
                rep_d   = '0;
              end
            end
            LONG: begin
              hold_d = hold_inc;
              if (REPEAT_CNT > 0) begin
                if (rep_inc == REP_TGT) begin
                  rpt_d = 1'b1;
                  rep_d = '0;
                end else begin
                  rep_d = rep_inc;
                end
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= INACTIVE;
      sync2_q <= INACTIVE;
      state_q <= IDLE;
      level_q <= 1'b0;
      stab_q  <= '0;
      hold_q  <= '0;
      rep_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      level_q <= level_d;
      stab_q  <= stab_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
    end
  end

  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = rpt_q;
endmodule

// File: rtl/key_debounce_array.sv
// N_KEYS independent debounce channels plus the
// key_any reduction of the debounced levels.
module key_debounce_array #(
  parameter int N_KEYS     = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int STABLE_CNT = 3,
  parameter int LONG_CNT   = 100,
  parameter int REPEAT_CNT = 20
) (
  input logic clk,
  input logic rst,
  key_debounce_array_if.slave bus
);
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] rel;
  logic [N_KEYS-1:0] lng;
  logic [N_KEYS-1:0] rpt;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_debounce_chan #(
      .ACTIVE_LOW (ACTIVE_LOW),
      .STABLE_CNT (STABLE_CNT),
      .LONG_CNT   (LONG_CNT),
      .REPEAT_CNT (REPEAT_CNT)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .sample_tick   (bus.sample_tick),
      .key_raw       (bus.key_raw[g]),
      .key_level     (level[g]),
      .press_pulse   (press[g]),
      .release_pulse (rel[g]),
      .long_pulse    (lng[g]),
      .repeat_pulse  (rpt[g])
    );
  end

  assign bus.key_level     = level;
  assign bus.press_pulse   = press;
  assign bus.release_pulse = rel;
  assign bus.long_pulse    = lng;
  assign bus.repeat_pulse  = rpt;
  assign bus.key_any       = |level;
endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: directed scenarios then
// random bouncing keys, checked against a tick-count model.
module tb_key_debounce_array;
  localparam int N  = 4;
  localparam int SC = 3;
  localparam int LC = 10;
  localparam int RC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [N-1:0] raw;

  always #5 clk = ~clk;

  key_debounce_array_if #(.N_KEYS(N)) bus_a ();
  key_debounce_array_if #(.N_KEYS(N)) bus_b ();

  assign bus_a.sample_tick = tick;
  assign bus_a.key_raw     = raw;
  assign bus_b.sample_tick = tick;
  assign bus_b.key_raw     = raw;

  key_debounce_array #(
    .N_KEYS(N), .ACTIVE_LOW(1), .STABLE_CNT(SC),
    .LONG_CNT(LC), .REPEAT_CNT(RC)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  key_debounce_array #(
    .N_KEYS(N), .ACTIVE_LOW(1), .STABLE_CNT(SC),
    .LONG_CNT(LC), .REPEAT_CNT(0)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // field 0 level, 1 press, 2 release, 3 long, 4 repeat
  logic [N-1:0] obs [2][5];
  logic         obs_any [2];
  assign obs[0][0] = bus_a.key_level;
  assign obs[0][1] = bus_a.press_pulse;
  assign obs[0][2] = bus_a.release_pulse;
  assign obs[0][3] = bus_a.long_pulse;
  assign obs[0][4] = bus_a.repeat_pulse;
  assign obs_any[0] = bus_a.key_any;
  assign obs[1][0] = bus_b.key_level;
  assign obs[1][1] = bus_b.press_pulse;
  assign obs[1][2] = bus_b.release_pulse;
  assign obs[1][3] = bus_b.long_pulse;
  assign obs[1][4] = bus_b.repeat_pulse;
  assign obs_any[1] = bus_b.key_any;

  // Model: ticks held since press decide long/repeat
  int           rep_of [2] = '{RC, 0};
  bit           m_s1 [2][N];
  bit           m_s2 [2][N];
  int           m_run [2][N];
  bit           m_lvl [2][N];
  int           m_held [2][N];
  logic [N-1:0] exp_o [2][5];

  always @(posedge clk) begin : model
    bit s;
    bit chg;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < N; k++) begin
        for (int f = 1; f < 5; f++) exp_o[i][f][k] = 1'b0;
        if (rst) begin
          m_s1[i][k]   = 1'b1;
          m_s2[i][k]   = 1'b1;
          m_run[i][k]  = 0;
          m_lvl[i][k]  = 1'b0;
          m_held[i][k] = 0;
        end else begin
          s = !m_s2[i][k];
          m_s2[i][k] = m_s1[i][k];
          m_s1[i][k] = raw[k];
          if (tick) begin
            chg = 1'b0;
            if (s == m_lvl[i][k]) m_run[i][k] = 0;
            else begin
              m_run[i][k]++;
              if (m_run[i][k] == SC) begin
                m_lvl[i][k] = s;
                m_run[i][k] = 0;
                chg = 1'b1;
              end
            end
            if (chg) begin
              m_held[i][k] = 0;
              if (m_lvl[i][k]) exp_o[i][1][k] = 1'b1;
              else exp_o[i][2][k] = 1'b1;
            end else if (m_lvl[i][k]) begin
              m_held[i][k]++;
              if (m_held[i][k] == LC)
                exp_o[i][3][k] = 1'b1;
              else if (rep_of[i] > 0 && m_held[i][k] > LC &&
                       (m_held[i][k] - LC) % rep_of[i] == 0)
                exp_o[i][4][k] = 1'b1;
            end
          end
        end
        exp_o[i][0][k] = m_lvl[i][k];
      end
    end
  end

  string fname [5] = '{"key_level", "press_pulse",
    "release_pulse", "long_pulse", "repeat_pulse"};

  int checks = 0;
  int errors = 0;
  int ticks  = 0;
  int phase  = 0;
  bit rand_mode = 1'b0;
  bit seen_all  = 1'b0;
  bit seen_pair = 1'b0;
  int cnt  [2][4][N];
  int base [2][4][N];

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      for (int f = 0; f < 5; f++) begin
        checks++;
        if (obs[i][f] !== exp_o[i][f]) begin
          errors++;
          $display("FAIL dut%0d %s t=%0t got %b want %b",
                   i, fname[f], $time, obs[i][f], exp_o[i][f]);
        end
      end
      checks++;
      if (obs_any[i] !== (|exp_o[i][0])) begin
        errors++;
        $display("FAIL dut%0d key_any t=%0t got %b want %b",
                 i, $time, obs_any[i], |exp_o[i][0]);
      end
      for (int t = 0; t < 4; t++)
        for (int k = 0; k < N; k++)
          cnt[i][t][k] += int'(obs[i][t+1][k] === 1'b1);
    end
    if (obs[0][1] === 4'hF) seen_all = 1'b1;
    if (obs[0][1][2] === 1'b1 && obs[0][2][3] === 1'b1)
      seen_pair = 1'b1;
    if (tick) ticks++;
    phase = (phase + 1) % 8;
    tick = rand_mode ? ($urandom_range(0, 2) == 0)
                     : (phase == 0);
  endtask

  task automatic wait_ticks(input int n);
    int t0;
    t0 = ticks;
    while (ticks < t0 + n) step();
  endtask

  task automatic snap();
    base = cnt;
  endtask

  task automatic chk(input string name, input int act,
                     input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  function automatic int dlt(input int i, input int t,
                             input int k);
    return cnt[i][t][k] - base[i][t][k];
  endfunction

  initial begin
    for (int i = 0; i < 2; i++)
      for (int t = 0; t < 4; t++)
        for (int k = 0; k < N; k++) cnt[i][t][k] = 0;
    snap();
    rst  = 1'b1;
    tick = 1'b0;
    raw  = '0;
    step();
    step();
    chk("reset_level", int'(obs[0][0]), 0);
    chk("reset_press", int'(obs[0][1]), 0);
    rst = 1'b0;
    wait_ticks(4);
    chk("all_pressed_level", int'(obs[0][0]), 15);
    chk("all_press_same_clk", int'(seen_all), 1);
    for (int k = 0; k < N; k++)
      chk($sformatf("press_once_%0d", k), dlt(0, 0, k), 1);
    raw = '1;
    wait_ticks(5);

    snap();
    raw[0] = 1'b0;
    wait_ticks(2);
    raw[0] = 1'b1;
    wait_ticks(3);
    chk("glitch_no_press", dlt(0, 0, 0), 0);
    chk("glitch_level", int'(obs[0][0][0]), 0);
    raw[0] = 1'b0;
    wait_ticks(3);
    chk("debounced_level", int'(obs[0][0][0]), 1);
    chk("debounced_press", dlt(0, 0, 0), 1);
    raw[0] = 1'b1;
    wait_ticks(4);

    snap();
    raw[1] = 1'b0;
    wait_ticks(25);
    chk("hold_press", dlt(0, 0, 1), 1);
    chk("hold_long", dlt(0, 2, 1), 1);
    chk("hold_repeats", dlt(0, 3, 1), 3);
    chk("norep_long", dlt(1, 2, 1), 1);
    chk("norep_repeats", dlt(1, 3, 1), 0);
    raw[1] = 1'b1;
    wait_ticks(6);
    chk("hold_release", dlt(0, 1, 1), 1);
    chk("no_repeat_after", dlt(0, 3, 1), 3);

    raw[3] = 1'b0;
    wait_ticks(4);
    snap();
    seen_pair = 1'b0;
    raw[2] = 1'b0;
    raw[3] = 1'b1;
    wait_ticks(4);
    chk("pair_same_clk", int'(seen_pair), 1);
    chk("pair_press2", dlt(0, 0, 2), 1);
    chk("pair_release3", dlt(0, 1, 3), 1);
    chk("any_high", int'(obs_any[0]), 1);
    raw[2] = 1'b1;
    wait_ticks(4);
    chk("any_low", int'(obs_any[0]), 0);

    snap();
    raw[0] = 1'b0;
    wait_ticks(14);
    chk("pre_rst_long", dlt(0, 2, 0), 1);
    snap();
    rst = 1'b1;
    step();
    chk("rst_level_drop", int'(obs[0][0][0]), 0);
    step();
    rst = 1'b0;
    chk("rst_no_release", dlt(0, 1, 0), 0);
    wait_ticks(5);
    chk("rst_repress", dlt(0, 0, 0), 1);
    wait_ticks(20);
    chk("norep_rebuild_long", dlt(1, 2, 0), 1);
    chk("norep_rebuild_rep", dlt(1, 3, 0), 0);
    raw[0] = 1'b1;
    wait_ticks(4);

    snap();
    raw[0] = 1'b0;
    wait_ticks(3);
    chk("tie_press", dlt(0, 0, 0), 1);
    wait_ticks(7);
    raw[0] = 1'b1;
    wait_ticks(3);
    chk("tie_level", int'(obs[0][0][0]), 0);
    chk("tie_release", dlt(0, 1, 0), 1);
    chk("tie_no_long", dlt(0, 2, 0), 0);
    wait_ticks(2);

    rand_mode = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0)
        raw[$urandom_range(0, N-1)] ^= 1'b1;
      rst = ($urandom_range(0, 1499) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
